// File: rtl/eff_pkg.sv
// Shared types and helpers for the effect-chain stages.
// Pure declarations: no timing, no flow control.
package eff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        S_LP,
        S_HP,
        S_BP
    } wah_state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } lfo_dir_e;

    // Clamp a signed value into the signed range of a w-bit word; callers cast the result down to w bits.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            sat_s = hi;
        else if (v < lo)
            sat_s = lo;
        else
            sat_s = v;
    endfunction

endpackage

// File: rtl/eff_lfo_tri.sv
// Triangle LFO bouncing between LO and HI, one step of `rate` per step strobe.
// Level updates on the edge after step; no backpressure, step is a plain strobe.
module eff_lfo_tri
    import eff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = 8,
    parameter int HI    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] rate,
    output logic [WIDTH-1:0] level
);

    localparam logic [WIDTH:0] LO_W = LO[WIDTH:0];
    localparam logic [WIDTH:0] HI_W = HI[WIDTH:0];

    lfo_dir_e              dir;
    logic [WIDTH:0]        up_sum;
    logic signed [WIDTH:0] dn_diff;

    // One extra bit keeps the sum/difference exact until the clamp decides.
    assign up_sum  = {1'b0, level} + {1'b0, rate};
    assign dn_diff = $signed({1'b0, level}) - $signed({1'b0, rate});

    always_ff @(posedge clk) begin
        if (!rst) begin
            level <= LO[WIDTH-1:0];
            dir   <= DIR_UP;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (up_sum >= HI_W) begin
                    level <= HI[WIDTH-1:0];
                    dir   <= DIR_DOWN;
                end else begin
                    level <= up_sum[WIDTH-1:0];
                end
            end else begin
                if (dn_diff <= $signed(LO_W)) begin
                    level <= LO[WIDTH-1:0];
                    dir   <= DIR_UP;
                end else begin
                    level <= dn_diff[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/eff_wah_sweep.sv
// Auto-wah: state-variable band-pass on one shared multiplier, cutoff swept by a triangle LFO; vld_o 4 cycles after accept.
// No backpressure: vld_i outside IDLE is dropped and latched in ovf_o; en=0 is a combinational bypass.
// Optional WAH_PEDAL_EN adds pedal_i/manual_i for a manually set cutoff.
module eff_wah_sweep
    import eff_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int GUARD      = 4,
    parameter int F_MIN      = 8,
    parameter int F_MAX      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [COEF_WIDTH-1:0] rate_i,
    input  logic [COEF_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
`ifdef WAH_PEDAL_EN
    input  logic [COEF_WIDTH-1:0] pedal_i,
    input  logic                  manual_i,
`endif
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  vld_o,
    output logic                  ovf_o
);

    localparam int ACC_WIDTH = DATA_WIDTH + GUARD;
    localparam int PW        = COEF_WIDTH + 1 + ACC_WIDTH;
    localparam int SW        = PW + 2;

    wah_state_e                   state;
    logic signed [ACC_WIDTH-1:0]  x, lp, hp, bp;
    logic [COEF_WIDTH-1:0]        f;
    logic [DATA_WIDTH-1:0]        data_r;
    logic                         vld_r;
    logic                         ovf_r;

    logic [COEF_WIDTH-1:0]        level;
    logic [COEF_WIDTH-1:0]        f_sel;
    logic [COEF_WIDTH-1:0]        mul_a;
    logic signed [ACC_WIDTH-1:0]  mul_b;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         sh;
    logic signed [SW-1:0]         sum;
    logic signed [ACC_WIDTH-1:0]  acc_new;
    logic signed [DATA_WIDTH-1:0] out_new;

    eff_lfo_tri #(
        .WIDTH (COEF_WIDTH),
        .LO    (F_MIN),
        .HI    (F_MAX)
    ) u_lfo (
        .clk   (clk),
        .rst   (rst),
        .step  (en && (state == S_BP)),
        .rate  (rate_i),
        .level (level)
    );

`ifdef WAH_PEDAL_EN
    localparam logic [COEF_WIDTH-1:0] F_LO = F_MIN[COEF_WIDTH-1:0];
    localparam logic [COEF_WIDTH-1:0] F_HI = F_MAX[COEF_WIDTH-1:0];

    always_comb begin
        f_sel = level;
        if (manual_i) begin
            if (pedal_i < F_LO)
                f_sel = F_LO;
            else if (pedal_i > F_HI)
                f_sel = F_HI;
            else
                f_sel = pedal_i;
        end
    end
`else
    assign f_sel = level;
`endif

    // One multiplier serves all three filter updates; each state feeds it what the previous state registered.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_LP: begin mul_a = f;   mul_b = bp; end
            S_HP: begin mul_a = q_i; mul_b = bp; end
            S_BP: begin mul_a = f;   mul_b = hp; end
            default: ;
        endcase
        prod = $signed({1'b0, mul_a}) * mul_b;
        sh   = (state == S_HP) ? (prod >>> (COEF_WIDTH - 1)) : (prod >>> COEF_WIDTH);
        case (state)
            S_HP:    sum = SW'(x) - SW'(lp) - SW'(sh);
            S_BP:    sum = SW'(bp) + SW'(sh);
            default: sum = SW'(lp) + SW'(sh);
        endcase
        acc_new = ACC_WIDTH'(sat_s(64'(sum), ACC_WIDTH));
        out_new = DATA_WIDTH'(sat_s(64'(acc_new), DATA_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            x      <= '0;
            f      <= '0;
            lp     <= '0;
            hp     <= '0;
            bp     <= '0;
            data_r <= '0;
            vld_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            vld_r <= 1'b0;
            if (!en) begin
                state <= IDLE;
                lp    <= '0;
                bp    <= '0;
            end else begin
                if (vld_i && (state != IDLE))
                    ovf_r <= 1'b1;
                case (state)
                    IDLE: if (vld_i) begin
                        x     <= ACC_WIDTH'($signed(data_i));
                        f     <= f_sel;
                        state <= S_LP;
                    end
                    S_LP: begin
                        lp    <= acc_new;
                        state <= S_HP;
                    end
                    S_HP: begin
                        hp    <= acc_new;
                        state <= S_BP;
                    end
                    S_BP: begin
                        bp     <= acc_new;
                        data_r <= out_new;
                        vld_r  <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign data_o = en ? data_r : data_i;
    assign vld_o  = en ? vld_r  : vld_i;
    assign ovf_o  = ovf_r;

endmodule

// File: tb/tb_eff_wah_sweep.sv
// Directed bench for eff_wah_sweep: three instances (sweeping, fixed f=32, fixed f=255) share one stimulus.
module tb_eff_wah_sweep;

    typedef struct {
        longint x;
        longint f;
        longint exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, vld_i;
    logic [7:0] rate_i, q_i, data_i;
    logic [7:0] d_sw, d_fx, d_st;
    logic       v_sw, v_fx, v_st, o_sw, o_fx, o_st;
`ifdef WAH_PEDAL_EN
    logic [7:0] pedal_i = 8'd0;
    logic       manual_i = 1'b0;
`endif

    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_lp, m_bp;

    always #5 clk = ~clk;

    eff_wah_sweep #(.F_MIN(8), .F_MAX(64)) u_sw (
        .clk(clk), .rst(rst), .en(en), .rate_i(rate_i), .q_i(q_i),
        .data_i(data_i), .vld_i(vld_i),
`ifdef WAH_PEDAL_EN
        .pedal_i(pedal_i), .manual_i(manual_i),
`endif
        .data_o(d_sw), .vld_o(v_sw), .ovf_o(o_sw)
    );

    eff_wah_sweep #(.F_MIN(32), .F_MAX(32)) u_fx (
        .clk(clk), .rst(rst), .en(en), .rate_i(rate_i), .q_i(q_i),
        .data_i(data_i), .vld_i(vld_i),
`ifdef WAH_PEDAL_EN
        .pedal_i(pedal_i), .manual_i(manual_i),
`endif
        .data_o(d_fx), .vld_o(v_fx), .ovf_o(o_fx)
    );

    eff_wah_sweep #(.F_MIN(255), .F_MAX(255)) u_st (
        .clk(clk), .rst(rst), .en(en), .rate_i(rate_i), .q_i(q_i),
        .data_i(data_i), .vld_i(vld_i),
`ifdef WAH_PEDAL_EN
        .pedal_i(pedal_i), .manual_i(manual_i),
`endif
        .data_o(d_st), .vld_o(v_st), .ovf_o(o_st)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference filter: the three SVF update equations with 12-bit state clamps.
    task automatic model_step(input longint x, input longint f, input longint q, output longint y);
        longint hp;
        m_lp = sat(m_lp + ((f * m_bp) >>> 8), 12);
        hp   = sat(x - m_lp - ((q * m_bp) >>> 7), 12);
        m_bp = sat(m_bp + ((f * hp) >>> 8), 12);
        y    = sat(m_bp, 8);
    endtask

    function automatic logic pick_vld(input int sel);
        case (sel)
            0:       return v_sw;
            1:       return v_fx;
            default: return v_st;
        endcase
    endfunction

    function automatic longint pick_data(input int sel);
        case (sel)
            0:       return longint'($signed(d_sw));
            1:       return longint'($signed(d_fx));
            default: return longint'($signed(d_st));
        endcase
    endfunction

    // Present one sample for one cycle and follow it for four cycles; vld_o must appear only in the fourth.
    task automatic send(input int sel, input longint x, output longint y);
        logic [3:0] pat;
        pat    = '0;
        y      = 0;
        data_i = 8'(x);
        vld_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vld_i = 1'b0;
            #1;
            pat[k] = pick_vld(sel);
            y      = pick_data(sel);
        end
        check("latency", longint'(pat), 64'd8);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        vld_i = 1'b0;
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        m_lp = 0;
        m_bp = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       imp[7];
        vec_t       swp[7];
        longint     y, e;
        logic [5:0] pat;

        imp[0] = '{x: 64,  f: 32, exp: 8};
        imp[1] = '{x: 0,   f: 32, exp: 6};
        imp[2] = '{x: 0,   f: 32, exp: 5};
        imp[3] = '{x: 0,   f: 32, exp: 4};
        imp[4] = '{x: 0,   f: 32, exp: 3};
        imp[5] = '{x: 0,   f: 32, exp: 2};
        imp[6] = '{x: -64, f: 32, exp: -7};

        swp[0] = '{x: 100, f: 8,  exp: 0};
        swp[1] = '{x: -50, f: 32, exp: 0};
        swp[2] = '{x: 30,  f: 56, exp: 0};
        swp[3] = '{x: 70,  f: 64, exp: 0};
        swp[4] = '{x: -90, f: 40, exp: 0};
        swp[5] = '{x: 60,  f: 16, exp: 0};
        swp[6] = '{x: -20, f: 8,  exp: 0};

        en = 1'b1; rate_i = 8'd0; q_i = 8'd128; data_i = 8'd0; vld_i = 1'b0;

        // Reset values
        do_reset();
        check("rst_data", longint'(d_fx), 0);
        check("rst_vld", longint'(v_fx), 0);
        check("rst_ovf", longint'(o_fx), 0);
        check("rst_data_sw", longint'(d_sw), 0);

        // Bypass is combinational
        en = 1'b0; data_i = 8'h5A; vld_i = 1'b1;
        #1;
        check("byp_data", longint'(d_sw), 64'h5A);
        check("byp_vld", longint'(v_sw), 1);
        @(negedge clk);
        data_i = 8'hA5; vld_i = 1'b0;
        #1;
        check("byp_data2", longint'(d_sw), 64'hA5);
        check("byp_vld2", longint'(v_sw), 0);
        check("byp_no_ovf", longint'(o_sw), 0);
        @(negedge clk);
        en = 1'b1;

        // Impulse response at f=32, q=1.0, back-to-back samples
        do_reset();
        foreach (imp[i]) begin
            send(1, imp[i].x, y);
            check("impulse", y, imp[i].exp);
        end

        // Triangle sweep 8..64, rate 24
        do_reset();
        rate_i = 8'd24;
        foreach (swp[i]) begin
            send(0, swp[i].x, y);
            model_step(swp[i].x, swp[i].f, 128, e);
            check("sweep", y, e);
        end
        rate_i = 8'd0;

        // Saturation at f=255, undamped
        do_reset();
        q_i = 8'd0;
        for (int i = 0; i < 20; i++) begin
            send(2, 127, y);
            model_step(127, 255, 0, e);
            check("sat_pos", y, e);
        end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(2, -128, y);
            model_step(-128, 255, 0, e);
            check("sat_neg", y, e);
        end
        q_i = 8'd128;

        // Overrun: second sample two cycles after the first is dropped
        do_reset();
        pat = '0;
        data_i = 8'd50; vld_i = 1'b1;
        @(negedge clk); vld_i = 1'b0; #1; pat[0] = v_sw;
        @(negedge clk); #1; pat[1] = v_sw;
        check("ovf_before", longint'(o_sw), 0);
        data_i = 8'(-100); vld_i = 1'b1;
        @(negedge clk); vld_i = 1'b0; #1; pat[2] = v_sw;
        check("ovf_set", longint'(o_sw), 1);
        @(negedge clk); #1; pat[3] = v_sw; y = longint'($signed(d_sw));
        @(negedge clk); #1; pat[4] = v_sw;
        @(negedge clk); #1; pat[5] = v_sw;
        check("ovf_pulse", longint'(pat), 64'd8);
        model_step(50, 8, 128, e);
        check("ovf_data", y, e);
        send(0, 20, y);
        model_step(20, 8, 128, e);
        check("ovf_next", y, e);
        check("ovf_sticky", longint'(o_sw), 1);
        do_reset();
        #1;
        check("ovf_cleared", longint'(o_sw), 0);

        // Abort by reset mid-computation
        pat = '0;
        data_i = 8'd64; vld_i = 1'b1;
        @(negedge clk); vld_i = 1'b0; #1; pat[0] = v_fx;
        @(negedge clk); rst = 1'b0;   #1; pat[1] = v_fx;
        @(negedge clk); rst = 1'b1;   #1; pat[2] = v_fx;
        @(negedge clk); #1; pat[3] = v_fx;
        check("abort_rst_vld", longint'(pat), 0);
        send(1, 64, y);
        check("abort_rst_next", y, 8);

        // Abort by en drop mid-computation; bypass also clears the filter state
        pat = '0;
        data_i = 8'd64; vld_i = 1'b1;
        @(negedge clk); vld_i = 1'b0; #1; pat[0] = v_fx;
        @(negedge clk); en = 1'b0;    #1; pat[1] = v_fx;
        @(negedge clk); en = 1'b1;    #1; pat[2] = v_fx;
        @(negedge clk); #1; pat[3] = v_fx;
        check("abort_en_vld", longint'(pat), 0);
        send(1, 64, y);
        check("abort_en_next", y, 8);
        check("abort_no_ovf", longint'(o_fx), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
